time_of_day_counter: RTL

//  Parametrised hh:mm:ss time-of-day counter with run/stop control, validated time-load handshake and 12/24-hour mode.

---
 rtl/time_of_day_counter.sv | 252 +++++++++++++++++++++++++
 1 files changed

// File: rtl/time_of_day_counter.sv
// hh:mm:ss time-of-day counter: prescaled second tick, run/stop, validated load, 12/24-hour mode.
// Optional alarm comparator enabled by defining ALARM_EN.
module time_of_day_counter #(
  parameter int unsigned TICK_DIV = 50_000_000,
  parameter bit          HOUR_24  = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       run,
  input  logic       set_valid,
  input  logic [4:0] set_hour,
  input  logic [6:0] set_min,
  input  logic [6:0] set_sec,
  input  logic       set_pm,
`ifdef ALARM_EN
  input  logic [4:0] alarm_hour,
  input  logic [6:0] alarm_min,
  input  logic       alarm_pm,
  input  logic       alarm_arm,
  output logic       alarm,
`endif
  output logic       set_ready,
  output logic       set_err,
  output logic [4:0] hour,
  output logic [6:0] cnt_minute,
  output logic [6:0] cnt_second,
  output logic       pm,
  output logic       new_day,
  output logic [2:0] state,
  output logic [2:0] nextState
);

  typedef enum logic [2:0] {
    ST_STOP = 3'd0,
    ST_RUN  = 3'd1,
    ST_LOAD = 3'd2
  } state_t;

  localparam int unsigned   PW        = $clog2(TICK_DIV);
  localparam logic [PW-1:0] PRE_LAST  = PW'(TICK_DIV - 1);
  localparam logic [4:0]    HOUR_RST  = HOUR_24 ? 5'd0 : 5'd12;

  state_t        state_q, state_d;
  logic [PW-1:0] pre_q, pre_d;
  logic [6:0]    sec_q, sec_d;
  logic [6:0]    min_q, min_d;
  logic [4:0]    hour_q, hour_d;
  logic          pm_q, pm_d;
  logic          new_day_q, new_day_d;
  logic          set_err_q, set_err_d;
  logic [6:0]    ld_sec_q, ld_sec_d;
  logic [6:0]    ld_min_q, ld_min_d;
  logic [4:0]    ld_hour_q, ld_hour_d;
  logic          ld_pm_q, ld_pm_d;

  logic set_ready_s;
  logic req_s;
  logic hour_ok_s;
  logic range_ok_s;
  logic accept_s;
  logic tick_s;

  // Handshake, range check and tick qualification; an accepted load swallows a coincident tick.
  always_comb begin
    set_ready_s = reset && (state_q != ST_LOAD);
    req_s       = set_valid && set_ready_s;
    if (HOUR_24) begin
      hour_ok_s = (set_hour <= 5'd23);
    end else begin
      hour_ok_s = (set_hour >= 5'd1) && (set_hour <= 5'd12);
    end
    range_ok_s = (set_sec <= 7'd59) && (set_min <= 7'd59) && hour_ok_s;
    accept_s   = req_s && range_ok_s;
    tick_s     = (state_q == ST_RUN) && run && (pre_q == PRE_LAST) && !accept_s;
    set_err_d  = req_s && !range_ok_s;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_STOP: begin
        if (accept_s) begin
          state_d = ST_LOAD;
        end else if (run) begin
          state_d = ST_RUN;
        end else begin
          state_d = ST_STOP;
        end
      end
      ST_RUN: begin
        if (accept_s) begin
          state_d = ST_LOAD;
        end else if (!run) begin
          state_d = ST_STOP;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_LOAD: begin
        if (run) begin
          state_d = ST_RUN;
        end else begin
          state_d = ST_STOP;
        end
      end
      default: state_d = ST_STOP;
    endcase
  end

  // Prescaler only advances while running; every other path returns it to zero.
  always_comb begin
    pre_d = '0;
    if ((state_q == ST_RUN) && run && !accept_s) begin
      if (pre_q == PRE_LAST) begin
        pre_d = '0;
      end else begin
        pre_d = pre_q + 1'b1;
      end
    end else begin
      pre_d = '0;
    end
  end

  // Load holding registers capture the request at acceptance; committed in LOAD.
  always_comb begin
    ld_sec_d  = ld_sec_q;
    ld_min_d  = ld_min_q;
    ld_hour_d = ld_hour_q;
    ld_pm_d   = ld_pm_q;
    if (accept_s) begin
      ld_sec_d  = set_sec;
      ld_min_d  = set_min;
      ld_hour_d = set_hour;
      ld_pm_d   = HOUR_24 ? 1'b0 : set_pm;
    end else begin
      ld_pm_d   = ld_pm_q;
    end
  end

  // Time arithmetic; in 12-hour mode midnight is 11 pm -> 12 am.
  always_comb begin
    sec_d     = sec_q;
    min_d     = min_q;
    hour_d    = hour_q;
    pm_d      = pm_q;
    new_day_d = 1'b0;
    if (state_q == ST_LOAD) begin
      sec_d  = ld_sec_q;
      min_d  = ld_min_q;
      hour_d = ld_hour_q;
      pm_d   = ld_pm_q;
    end else if (tick_s) begin
      if (sec_q == 7'd59) begin
        sec_d = 7'd0;
        if (min_q == 7'd59) begin
          min_d = 7'd0;
          if (HOUR_24) begin
            if (hour_q == 5'd23) begin
              hour_d    = 5'd0;
              new_day_d = 1'b1;
            end else begin
              hour_d = hour_q + 5'd1;
            end
          end else begin
            if (hour_q == 5'd12) begin
              hour_d = 5'd1;
            end else if (hour_q == 5'd11) begin
              hour_d    = 5'd12;
              pm_d      = ~pm_q;
              new_day_d = pm_q;
            end else begin
              hour_d = hour_q + 5'd1;
            end
          end
        end else begin
          min_d = min_q + 7'd1;
        end
      end else begin
        sec_d = sec_q + 7'd1;
      end
    end else begin
      new_day_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_STOP;
      pre_q     <= '0;
      sec_q     <= 7'd0;
      min_q     <= 7'd0;
      hour_q    <= HOUR_RST;
      pm_q      <= 1'b0;
      new_day_q <= 1'b0;
      set_err_q <= 1'b0;
      ld_sec_q  <= 7'd0;
      ld_min_q  <= 7'd0;
      ld_hour_q <= 5'd0;
      ld_pm_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      pre_q     <= pre_d;
      sec_q     <= sec_d;
      min_q     <= min_d;
      hour_q    <= hour_d;
      pm_q      <= pm_d;
      new_day_q <= new_day_d;
      set_err_q <= set_err_d;
      ld_sec_q  <= ld_sec_d;
      ld_min_q  <= ld_min_d;
      ld_hour_q <= ld_hour_d;
      ld_pm_q   <= ld_pm_d;
    end
  end

`ifdef ALARM_EN
  logic alarm_q, alarm_d;

  // Alarm compares the post-tick time, so loads can never fire it.
  always_comb begin
    alarm_d = 1'b0;
    if (tick_s && alarm_arm && (hour_d == alarm_hour) && (min_d == alarm_min) &&
        (sec_d == 7'd0) && (HOUR_24 || (pm_d == alarm_pm))) begin
      alarm_d = 1'b1;
    end else begin
      alarm_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      alarm_q <= 1'b0;
    end else begin
      alarm_q <= alarm_d;
    end
  end

  assign alarm = alarm_q;
`endif

  assign set_ready  = set_ready_s;
  assign set_err    = set_err_q;
  assign hour       = hour_q;
  assign cnt_minute = min_q;
  assign cnt_second = sec_q;
  assign pm         = pm_q;
  assign new_day    = new_day_q;
  assign state      = state_q;
  assign nextState  = state_d;

endmodule
